// File: rtl/accelerator_scalar_integer_reducer.sv
// ---------------------------------------------------------------------------
// accelerator_scalar_integer_reducer
//
// Purpose:
//   Sequential modular reduction, DATA_OUT = DATA_IN mod MODULO_IN.
//   It uses restoring shift-subtract and retires one dividend bit per clock.
//   It sits in front of the scalar integer modular multiplier and brings
//   arbitrary operands into [0, m). It uses the family START/READY one-shot
//   handshake.
//
// Parameters:
//   DATA_SIZE    - operand/result width in bits (>= 2)
//   CONTROL_SIZE - kept for family uniformity; unused internally
//
// Ports:
//   CLK          in   rising-edge clock
//   RST          in   synchronous reset, active-high
//   START        in   request, sampled only while idle (STARTER_STATE)
//   READY        out  one-cycle pulse, DATA_OUT (and QUOTIENT_OUT) valid
//   MODULO_IN    in   modulus m, unsigned, captured on START
//   DATA_IN      in   dividend x, unsigned, captured on START
//   DATA_OUT     out  registered remainder x mod m; m = 0 passes x through
//   QUOTIENT_OUT out  registered quotient x / m; all ones for m = 0
//                     (present only with the macro below)
//
// Configuration macro:
//   ACCELERATOR_SCALAR_INTEGER_REDUCER_QUOTIENT_EN - adds QUOTIENT_OUT.
//
// Latency, counting from the edge that samples START:
//   m != 0 : READY is high after edge DATA_SIZE+1
//   m == 0 : READY is high after edge 1
// ---------------------------------------------------------------------------
module accelerator_scalar_integer_reducer #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  input  logic [DATA_SIZE-1:0] MODULO_IN,
  input  logic [DATA_SIZE-1:0] DATA_IN,
  output logic [DATA_SIZE-1:0] DATA_OUT
`ifdef ACCELERATOR_SCALAR_INTEGER_REDUCER_QUOTIENT_EN
  ,
  output logic [DATA_SIZE-1:0] QUOTIENT_OUT
`endif
);

  localparam int CW = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;

  // CONTROL_SIZE exists only so every block in the family has the same
  // parameter list. This block has no use for it.
  if (CONTROL_SIZE < 0) begin : g_control_size_unused
  end

  typedef enum logic [1:0] {
    STARTER_STATE = 2'd0,
    REDUCE_STATE  = 2'd1,
    ENDER_STATE   = 2'd2
  } state_t;

  state_t               state_q,     state_d;
  logic                 ready_q,     ready_d;
  logic [DATA_SIZE-1:0] data_out_q,  data_out_d;
  // One bit wider than the operands. This keeps the shift from overflowing
  // when the modulus has its MSB set.
  logic [DATA_SIZE:0]   remainder_q, remainder_d;
  logic [DATA_SIZE-1:0] dividend_q,  dividend_d;
  logic [DATA_SIZE-1:0] modulo_q,    modulo_d;
  logic [CW-1:0]        index_q,     index_d;

`ifdef ACCELERATOR_SCALAR_INTEGER_REDUCER_QUOTIENT_EN
  logic [DATA_SIZE-1:0] quotient_q,     quotient_d;
  logic [DATA_SIZE-1:0] quotient_out_q, quotient_out_d;
`endif

  // The trial value shifts the next dividend bit into the remainder.
  // Between iterations the remainder is always below m, so its top bit is
  // zero. That bit still takes part in the comparison, which makes the
  // compare span the full register. The difference only needs DATA_SIZE+1
  // bits, because a subtraction only happens when trial >= m.
  logic [DATA_SIZE+1:0] trial_w;
  logic [DATA_SIZE:0]   diff_w;
  logic                 fits_w;

  assign trial_w = {remainder_q, dividend_q[DATA_SIZE-1]};
  assign fits_w  = (trial_w >= {2'b00, modulo_q});
  assign diff_w  = trial_w[DATA_SIZE:0] - {1'b0, modulo_q};

  // -------------------------------------------------------------------------
  // Next-state and datapath logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: each _d first takes its hold value (ready_d defaults to 0, which
    // is what makes READY a pulse). No path through the case can leave a
    // variable unassigned, so no latch is inferred.
    state_d     = state_q;
    ready_d     = 1'b0;
    data_out_d  = data_out_q;
    remainder_d = remainder_q;
    dividend_d  = dividend_q;
    modulo_d    = modulo_q;
    index_d     = index_q;
`ifdef ACCELERATOR_SCALAR_INTEGER_REDUCER_QUOTIENT_EN
    quotient_d     = quotient_q;
    quotient_out_d = quotient_out_q;
`endif

    case (state_q)
      STARTER_STATE: begin
        if (START) begin
          dividend_d = DATA_IN;
          modulo_d   = MODULO_IN;
          index_d    = CW'(DATA_SIZE - 1);
          if (MODULO_IN == '0) begin
            // Defined pass-through. The dividend is the result as is.
            remainder_d = {1'b0, DATA_IN};
            state_d     = ENDER_STATE;
`ifdef ACCELERATOR_SCALAR_INTEGER_REDUCER_QUOTIENT_EN
            quotient_d  = '1;
`endif
          end else begin
            remainder_d = '0;
            state_d     = REDUCE_STATE;
`ifdef ACCELERATOR_SCALAR_INTEGER_REDUCER_QUOTIENT_EN
            quotient_d  = '0;
`endif
          end
        end
      end

      REDUCE_STATE: begin
        remainder_d = fits_w ? diff_w : trial_w[DATA_SIZE:0];
        dividend_d  = {dividend_q[DATA_SIZE-2:0], 1'b0};
`ifdef ACCELERATOR_SCALAR_INTEGER_REDUCER_QUOTIENT_EN
        quotient_d  = {quotient_q[DATA_SIZE-2:0], fits_w};
`endif
        if (index_q == '0) begin
          state_d = ENDER_STATE;
        end else begin
          index_d = index_q - CW'(1);
        end
      end

      ENDER_STATE: begin
        data_out_d = remainder_q[DATA_SIZE-1:0];
        ready_d    = 1'b1;
        state_d    = STARTER_STATE;
`ifdef ACCELERATOR_SCALAR_INTEGER_REDUCER_QUOTIENT_EN
        quotient_out_d = quotient_q;
`endif
      end

      // The unused encoding falls back to idle.
      default: begin
        state_d = STARTER_STATE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    // NOTE: reset is synchronous and clears every register, datapath
    // included. An aborted request therefore leaves nothing behind that
    // could leak into the next result.
    if (RST) begin
      state_q     <= STARTER_STATE;
      ready_q     <= 1'b0;
      data_out_q  <= '0;
      remainder_q <= '0;
      dividend_q  <= '0;
      modulo_q    <= '0;
      index_q     <= '0;
`ifdef ACCELERATOR_SCALAR_INTEGER_REDUCER_QUOTIENT_EN
      quotient_q     <= '0;
      quotient_out_q <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments, so every register samples the _d
      // values of the same edge regardless of statement order.
      state_q     <= state_d;
      ready_q     <= ready_d;
      data_out_q  <= data_out_d;
      remainder_q <= remainder_d;
      dividend_q  <= dividend_d;
      modulo_q    <= modulo_d;
      index_q     <= index_d;
`ifdef ACCELERATOR_SCALAR_INTEGER_REDUCER_QUOTIENT_EN
      quotient_q     <= quotient_d;
      quotient_out_q <= quotient_out_d;
`endif
    end
  end

  assign READY    = ready_q;
  assign DATA_OUT = data_out_q;
`ifdef ACCELERATOR_SCALAR_INTEGER_REDUCER_QUOTIENT_EN
  assign QUOTIENT_OUT = quotient_out_q;
`endif

endmodule
